uart_tx_buffer: RTL and testbench

- Elastic byte buffer between the UART receiver's byte output and the UART transmitter's send/data input.
- Absorbs bursts while the transmitter is serialising, so received bytes are not lost during echo or loopback.
- Contains two parts:
  - a synchronous FIFO, written by receiver strobes;
  - a read-side state machine that issues one-cycle send pulses to the transmitter, paced by the transmitter's busy flag.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_tx_buffer_if.sv | 29 ++
 rtl/uart_tx_buffer_sync_fifo.sv | 69 ++++++
 rtl/uart_tx_buffer.sv | 89 ++++++++
 tb/tb_uart_tx_buffer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and the transmit-side send FSM states.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } tx_state_t;

endpackage

// File: rtl/uart_tx_buffer_if.sv
// Byte-in / send-out bundle between the UART receiver, the buffer and the transmitter.
interface uart_tx_buffer_if
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = UART_DATA_W
);

  logic                     in_valid;
  logic [DATA_W-1:0]        in_data;
  logic                     tx_busy;
  logic                     tx_send;
  logic [DATA_W-1:0]        tx_data;
  logic [$clog2(DEPTH):0]   count;
  logic                     full;
  logic                     empty;
  logic                     overflow;

  modport master (
    output in_valid, in_data, tx_busy,
    input  tx_send, tx_data, count, full, empty, overflow
  );

  modport slave (
    input  in_valid, in_data, tx_busy,
    output tx_send, tx_data, count, full, empty, overflow
  );

endinterface

// File: rtl/uart_tx_buffer_sync_fifo.sv
// Synchronous FIFO with registered count/full/empty and a sticky overflow flag.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  output logic [DATA_W-1:0]      pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_next;
  logic              do_push;
  logic              do_pop;

  // full is the pre-cycle registered value, so a same-cycle pop cannot make room
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_next = count + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
      if (push && full) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Elastic byte buffer feeding a UART transmitter; one send pulse per byte, paced by tx_busy.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int DATA_W   = UART_DATA_W,
  parameter int ACK_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_buffer_if.slave bus
);

  localparam int TW = $clog2(ACK_WAIT + 1);

  tx_state_t         state;
  tx_state_t         state_next;
  logic [TW-1:0]     timer;
  logic              send_next;
  logic              tx_send;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_empty;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.in_valid),
    .push_data (bus.in_data),
    .pop       (send_next),
    .pop_data  (fifo_data),
    .count     (bus.count),
    .full      (bus.full),
    .empty     (fifo_empty),
    .overflow  (bus.overflow)
  );

  assign bus.empty   = fifo_empty;
  assign bus.tx_send = tx_send;
  assign bus.tx_data = tx_data;

  always_comb begin
    state_next = state;
    send_next  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !bus.tx_busy) begin
          send_next  = 1'b1;
          state_next = WAIT_BUSY;
        end
      end
      // The send-pulse cycle itself is not counted: busy cannot rise before the
      // transmitter has latched, so ACK_WAIT cycles are allowed after it.
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_next = WAIT_DONE;
        end else if (timer == TW'(ACK_WAIT)) begin
          state_next = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      tx_send <= 1'b0;
      tx_data <= '0;
    end else begin
      state   <= state_next;
      tx_send <= send_next;
      if (send_next) begin
        tx_data <= fifo_data;
      end
      timer <= (state == WAIT_BUSY) ? timer + TW'(1) : '0;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer: latency, pacing, overflow, timeout and reset scenarios.
module tb_uart_tx_buffer;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] sent_q[$];
  int         sent_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_buffer_if #(.DEPTH(16), .DATA_W(8)) bus ();

  uart_tx_buffer #(.DEPTH(16), .DATA_W(8), .ACK_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(negedge clk) begin
    if (!rst && bus.tx_send) begin
      sent_q.push_back(bus.tx_data);
      sent_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sent_q.delete();
    sent_cyc.delete();
  endtask

  task automatic push_byte(input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.tx_busy = 1'b0;
    do_reset();
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", bus.full); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
    checks++; if (bus.tx_send !== 1'b0) begin errors++; $display("FAIL reset_tx_send got %b want 0", bus.tx_send); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", bus.tx_data); end
  endtask

  task automatic test_single();
    bus.tx_busy = 1'b0;
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h41;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.tx_send !== 1'b0) begin errors++; $display("FAIL single_early_send got %b want 0", bus.tx_send); end
    checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL single_count1 got %0d want 1", bus.count); end
    checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL single_not_empty got %b want 0", bus.empty); end
    tick();
    checks++; if (bus.tx_send !== 1'b1) begin errors++; $display("FAIL single_send got %b want 1", bus.tx_send); end
    checks++; if (bus.tx_data !== 8'h41) begin errors++; $display("FAIL single_data got %h want 41", bus.tx_data); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL single_count0 got %0d want 0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL single_empty got %b want 1", bus.empty); end
    tick();
    checks++; if (bus.tx_send !== 1'b0) begin errors++; $display("FAIL single_pulse_width got %b want 0", bus.tx_send); end
  endtask

  task automatic test_burst();
    logic [7:0] got [3];
    int         at [3];
    int         nsent;
    int         busy_left;
    int         unstable;
    nsent     = 0;
    busy_left = 0;
    unstable  = 0;
    bus.tx_busy = 1'b0;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      bus.in_valid = (i < 3);
      bus.in_data  = 8'(8'h10 + i);
      if (busy_left > 0) busy_left--;
      bus.tx_busy = (busy_left > 0);
      tick();
      if (bus.tx_send) begin
        if (nsent < 3) begin
          got[nsent] = bus.tx_data;
          at[nsent]  = i;
        end
        nsent++;
        busy_left = 21;
      end else if (bus.tx_busy && nsent > 0 && nsent <= 3 && bus.tx_data !== got[nsent-1]) begin
        unstable++;
      end
    end
    bus.in_valid = 1'b0;
    bus.tx_busy  = 1'b0;
    checks++; if (nsent !== 3) begin errors++; $display("FAIL burst_nsent got %0d want 3", nsent); end
    if (nsent >= 3) begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (got[k] !== 8'(8'h10 + k)) begin errors++; $display("FAIL burst_data%0d got %h want %h", k, got[k], 8'(8'h10 + k)); end
      end
      for (int k = 1; k < 3; k++) begin
        checks++; if (at[k] - at[k-1] <= 20) begin errors++; $display("FAIL burst_gap%0d got %0d want >20", k, at[k] - at[k-1]); end
      end
    end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL burst_data_stable got %0d changes want 0", unstable); end
  endtask

  task automatic test_overflow();
    int bad;
    bad = 0;
    bus.tx_busy = 1'b1;
    do_reset();
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL ovf_count16 got %0d want 16", bus.count); end
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b want 1", bus.full); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_not_yet got %b want 0", bus.overflow); end
    push_byte(8'h10);
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", bus.overflow); end
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL ovf_count_hold got %0d want 16", bus.count); end
    bus.tx_busy = 1'b0;
    for (int i = 0; i < 110; i++) tick();
    checks++; if (sent_q.size() !== 16) begin errors++; $display("FAIL ovf_drain_size got %0d want 16", sent_q.size()); end
    for (int k = 0; k < sent_q.size() && k < 16; k++) begin
      if (sent_q[k] !== 8'(k)) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL ovf_drain_order got %0d wrong bytes want 0", bad); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL ovf_drain_empty got %b want 1", bus.empty); end
  endtask

  task automatic test_full_pop();
    bus.tx_busy = 1'b1;
    do_reset();
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    bus.tx_busy  = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    bus.tx_busy  = 1'b1;
    checks++; if (bus.tx_send !== 1'b1) begin errors++; $display("FAIL fullpop_send got %b want 1", bus.tx_send); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL fullpop_data got %h want 00", bus.tx_data); end
    checks++; if (bus.count !== 5'd15) begin errors++; $display("FAIL fullpop_count got %0d want 15", bus.count); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL fullpop_full got %b want 0", bus.full); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL fullpop_overflow got %b want 1", bus.overflow); end
    tick();
    tick();
    checks++; if (bus.count !== 5'd15) begin errors++; $display("FAIL fullpop_count_later got %0d want 15", bus.count); end
    do_reset();
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf_cleared got %b want 0", bus.overflow); end
  endtask

  task automatic test_ack_timeout();
    bus.tx_busy = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) push_byte(8'(8'hA0 + i));
    for (int i = 0; i < 40; i++) tick();
    checks++; if (sent_q.size() !== 4) begin errors++; $display("FAIL ack_nsent got %0d want 4", sent_q.size()); end
    if (sent_q.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (sent_q[k] !== 8'(8'hA0 + k)) begin errors++; $display("FAIL ack_data%0d got %h want %h", k, sent_q[k], 8'(8'hA0 + k)); end
      end
      for (int k = 1; k < 4; k++) begin
        checks++; if (sent_cyc[k] - sent_cyc[k-1] !== 6) begin errors++; $display("FAIL ack_spacing%0d got %0d want 6", k, sent_cyc[k] - sent_cyc[k-1]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.tx_busy = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(8'hB0 + i);
      tick();
      if (bus.tx_send) bus.tx_busy = 1'b1;
    end
    bus.in_valid = 1'b0;
    checks++; if (bus.count !== 5'd5) begin errors++; $display("FAIL mid_count5 got %0d want 5", bus.count); end
    checks++; if (dut.state !== WAIT_DONE) begin errors++; $display("FAIL mid_state_done got %0d want %0d", dut.state, WAIT_DONE); end
    do_reset();
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL mid_count0 got %0d want 0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL mid_empty got %b want 1", bus.empty); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow got %b want 0", bus.overflow); end
    checks++; if (bus.tx_send !== 1'b0) begin errors++; $display("FAIL mid_tx_send got %b want 0", bus.tx_send); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL mid_tx_data got %h want 00", bus.tx_data); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL mid_state_idle got %0d want %0d", dut.state, IDLE); end
    bus.tx_busy = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    checks++; if (sent_q.size() !== 0) begin errors++; $display("FAIL mid_no_send got %0d want 0", sent_q.size()); end
    push_byte(8'hC5);
    for (int i = 0; i < 4; i++) tick();
    checks++; if (sent_q.size() !== 1) begin errors++; $display("FAIL mid_new_send got %0d want 1", sent_q.size()); end
    if (sent_q.size() == 1) begin
      checks++; if (sent_q[0] !== 8'hC5) begin errors++; $display("FAIL mid_new_data got %h want c5", sent_q[0]); end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.tx_busy  = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_full_pop();
    test_ack_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
